// File: rtl/pfb_snapshot_buffer_if.sv
// Readback port of the snapshot buffer. The host drives the address and request,
// and the buffer returns the data and its qualifier.
interface pfb_snapshot_buffer_if #(
    parameter int AW   = 10,
    parameter int LR   = 1,
    parameter int RD_W = 32
);
    logic              rd_en;
    logic [AW+LR-1:0]  rd_addr;
    logic [RD_W-1:0]   rd_data;
    logic              rd_valid;

    modport master (output rd_en, output rd_addr, input rd_data, input rd_valid);
    modport slave  (input rd_en, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/pfb_snapshot_buffer.sv
// Trigger-based snapshot buffer: one-shot or circular pre-trigger capture into a
// 2^AW x DIN_W RAM, read back in RD_W lanes with a fixed two-cycle latency.
module pfb_snapshot_buffer #(
    parameter int DIN_W = 64,
    parameter int AW    = 10,
    parameter int RD_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 mode_circ,
    input  logic [AW-1:0]        post_len,
    input  logic                 din_valid,
    input  logic [DIN_W-1:0]     din,
    input  logic                 trig,
    output logic                 busy,
    output logic                 done,
    output logic                 wrapped,
    output logic [AW-1:0]        trig_addr,
    pfb_snapshot_buffer_if.slave rd
);
    localparam int R     = DIN_W / RD_W;
    localparam int LR    = (R == 4) ? 2 : (R == 2) ? 1 : 0;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [AW:0]       cnt_inc, cnt_target;
    logic [AW-1:0]     post_q, post_d;
    logic [AW-1:0]     trig_addr_q, trig_addr_d;
    logic              circ_q, circ_d;
    logic              wrapped_q, wrapped_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we;

    assign cnt_inc    = cnt_q + {{AW{1'b0}}, 1'b1};
    // One-shot fills the whole buffer; circular stops after post_len post-trigger words.
    assign cnt_target = circ_q ? {1'b0, post_q} : (AW+1)'(DEPTH);

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        post_d      = post_q;
        trig_addr_d = trig_addr_q;
        circ_d      = circ_q;
        wrapped_d   = wrapped_q;
        we          = 1'b0;

        if (arm) begin
            state_d   = WAIT_TRIG;
            wr_ptr_d  = '0;
            cnt_d     = '0;
            wrapped_d = 1'b0;
            circ_d    = mode_circ;
            post_d    = post_len;
        end else begin
            unique case (state_q)
                WAIT_TRIG: begin
                    if (din_valid && (circ_q || trig)) begin
                        we = 1'b1;
                        if (trig) begin
                            trig_addr_d = wr_ptr_q;
                            cnt_d       = circ_q ? '0 : {{AW{1'b0}}, 1'b1};
                            state_d     = (circ_q && post_q == '0) ? DONE : CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (din_valid) begin
                        we    = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == cnt_target) state_d = DONE;
                    end
                end
                default: ;
            endcase

            if (we) begin
                wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                if (&wr_ptr_q) wrapped_d = 1'b1;
            end
        end

        busy_d = (state_d inside {WAIT_TRIG, CAPTURE});
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            post_q      <= '0;
            trig_addr_q <= '0;
            circ_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            post_q      <= post_d;
            trig_addr_q <= trig_addr_d;
            circ_q      <= circ_d;
            wrapped_q   <= wrapped_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
    assign trig_addr = trig_addr_q;

    // ---------------- storage and readback ----------------
    logic [DIN_W-1:0] mem [DEPTH];
    logic [DIN_W-1:0] ram_rd_q;
    logic [AW-1:0]    rd_word;
    logic [1:0]       rd_lane;
    logic [1:0]       lane_q, lane_d;
    logic             rd_v1_q, rd_v1_d;
    logic             rd_valid_q, rd_valid_d;
    logic [RD_W-1:0]  rd_data_q, rd_data_d;

    assign rd_word = rd.rd_addr[AW+LR-1:LR];
    if (LR == 0) begin : g_one_lane
        assign rd_lane = '0;
    end else begin : g_multi_lane
        assign rd_lane = 2'(rd.rd_addr[LR-1:0]);
    end

    // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (we)       mem[wr_ptr_q] <= din;
        if (rd.rd_en) ram_rd_q      <= mem[rd_word];
    end

    always_comb begin
        rd_v1_d    = rd.rd_en;
        lane_d     = rd.rd_en ? rd_lane : lane_q;
        rd_valid_d = rd_v1_q;
        rd_data_d  = rd_v1_q ? RD_W'(ram_rd_q >> (lane_q * RD_W)) : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q    <= 1'b0;
            lane_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_v1_q    <= rd_v1_d;
            lane_q     <= lane_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_pfb_snapshot_buffer.sv
// Directed bench for pfb_snapshot_buffer (DIN_W=64, AW=4, RD_W=32): one-shot,
// circular, stall, collision, reset and readback-throughput scenarios.
module tb_pfb_snapshot_buffer;
    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        mode_circ;
    logic [3:0]  post_len;
    logic        din_valid;
    logic [63:0] din;
    logic        trig;
    logic        busy;
    logic        done;
    logic        wrapped;
    logic [3:0]  trig_addr;

    int n_checks = 0;
    int n_fail   = 0;

    pfb_snapshot_buffer_if #(.AW(4), .LR(1), .RD_W(32)) rd_if ();

    pfb_snapshot_buffer #(.DIN_W(64), .AW(4), .RD_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .mode_circ (mode_circ),
        .post_len  (post_len),
        .din_valid (din_valid),
        .din       (din),
        .trig      (trig),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped),
        .trig_addr (trig_addr),
        .rd        (rd_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic t, input logic [63:0] d);
        din_valid = v;
        trig      = t;
        din       = d;
        step();
    endtask

    task automatic quiet();
        din_valid = 1'b0;
        trig      = 1'b0;
    endtask

    task automatic arm_cap(input logic mc, input logic [3:0] pl);
        arm       = 1'b1;
        mode_circ = mc;
        post_len  = pl;
        step();
        arm       = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        rd_if.rd_en   = 1'b1;
        rd_if.rd_addr = addr;
        step();
        rd_if.rd_en = 1'b0;
        check({tag, "_lat1_valid"}, 64'(rd_if.rd_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(rd_if.rd_valid), 64'd1);
        check({tag, "_data"}, 64'(rd_if.rd_data), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; arm = 1'b0; mode_circ = 1'b0; post_len = '0;
        din_valid = 1'b0; din = '0; trig = 1'b0;
        rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wrapped", 64'(wrapped), 64'd0);
        check("rst_trig_addr", 64'(trig_addr), 64'd0);
        check("rst_rd_valid", 64'(rd_if.rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_if.rd_data), 64'd0);
        rst_n = 1'b1;

        // One-shot: trigger word then 15 incrementing words fill all 16 entries.
        arm_cap(1'b0, 4'd0);
        check("os_armed_busy", 64'(busy), 64'd1);
        repeat (3) send(1'b0, 1'b0, 64'h0);
        send(1'b1, 1'b1, 64'h0000_0001_0000_0000);
        check("os_trig_addr", 64'(trig_addr), 64'd0);
        for (int k = 1; k < 16; k++) begin
            send(1'b1, 1'b0, 64'h0000_0001_0000_0000 + 64'(k));
            if (k == 14) check("os_done_early", 64'(done), 64'd0);
        end
        quiet();
        check("os_done", 64'(done), 64'd1);
        check("os_busy_low", 64'(busy), 64'd0);
        check("os_wrapped", 64'(wrapped), 64'd1);
        rd_check("os_rd0", 5'd0, 32'h0000_0000);
        rd_check("os_rd1", 5'd1, 32'h0000_0001);
        rd_check("os_rd30", 5'd30, 32'h0000_000F);

        // Throughput: 32 back-to-back reads of the one-shot buffer.
        for (int i = 0; i < 34; i++) begin
            rd_if.rd_en   = (i < 32);
            rd_if.rd_addr = 5'(i);
            step();
            if (i >= 1 && i <= 32) begin
                check("tp_valid", 64'(rd_if.rd_valid), 64'd1);
                check("tp_data", 64'(rd_if.rd_data),
                      ((i - 1) % 2 == 1) ? 64'd1 : 64'((i - 1) / 2));
            end else if (i == 33) begin
                check("tp_valid_end", 64'(rd_if.rd_valid), 64'd0);
            end
        end
        rd_if.rd_en = 1'b0;

        // Circular: words 0..20, trigger on word 17, three post-trigger words.
        arm_cap(1'b1, 4'd3);
        check("circ_wrapped_cleared", 64'(wrapped), 64'd0);
        for (int k = 0; k <= 20; k++) begin
            send(1'b1, (k == 17), {32'h1000 + 32'(k), 32'(k)});
            if (k == 17) check("circ_trig_addr", 64'(trig_addr), 64'd1);
            if (k == 19) check("circ_done_early", 64'(done), 64'd0);
        end
        quiet();
        check("circ_done", 64'(done), 64'd1);
        check("circ_wrapped", 64'(wrapped), 64'd1);
        rd_check("circ_w4_lo", 5'd8, 32'd20);
        rd_check("circ_w4_hi", 5'd9, 32'h1014);
        rd_check("circ_w5_lo", 5'd10, 32'd5);
        rd_check("circ_w1_lo", 5'd2, 32'd17);

        // Stall: valid pattern 1,0,1 after the trigger with post_len=2.
        arm_cap(1'b1, 4'd2);
        send(1'b1, 1'b1, 64'hA0);
        check("stall_trig_addr", 64'(trig_addr), 64'd0);
        send(1'b1, 1'b0, 64'hA1);
        check("stall_done_1", 64'(done), 64'd0);
        send(1'b0, 1'b0, 64'hEE);
        check("stall_done_2", 64'(done), 64'd0);
        check("stall_busy_2", 64'(busy), 64'd1);
        send(1'b1, 1'b0, 64'hA2);
        quiet();
        check("stall_done_3", 64'(done), 64'd1);
        check("stall_no_wrap", 64'(wrapped), 64'd0);
        rd_check("stall_w1", 5'd2, 32'hA1);
        rd_check("stall_w2", 5'd4, 32'hA2);

        // Collision: arm and trig together from DONE; then trig while DONE.
        arm = 1'b1; mode_circ = 1'b1; post_len = 4'd1;
        din_valid = 1'b1; trig = 1'b1; din = 64'hBAD;
        step();
        arm = 1'b0;
        quiet();
        check("coll_busy", 64'(busy), 64'd1);
        check("coll_done", 64'(done), 64'd0);
        check("coll_trig_addr", 64'(trig_addr), 64'd0);
        rd_check("coll_no_write", 5'd0, 32'hA0);
        send(1'b1, 1'b0, 64'hC0);
        send(1'b1, 1'b1, 64'hC1);
        check("coll_trig_addr2", 64'(trig_addr), 64'd1);
        send(1'b1, 1'b0, 64'hC2);
        check("coll_done2", 64'(done), 64'd1);
        send(1'b1, 1'b1, 64'hDD);
        quiet();
        check("done_trig_addr", 64'(trig_addr), 64'd1);
        check("done_stays", 64'(done), 64'd1);
        rd_check("done_no_write", 5'd6, 32'd19);
        rd_check("coll_w2", 5'd4, 32'hC2);

        // Reset mid-capture with a read result on the output.
        arm_cap(1'b0, 4'd0);
        send(1'b1, 1'b1, 64'h55);
        send(1'b1, 1'b0, 64'h56);
        send(1'b1, 1'b0, 64'h57);
        rd_if.rd_en = 1'b1; rd_if.rd_addr = 5'd0;
        send(1'b1, 1'b0, 64'h58);
        rd_if.rd_en = 1'b0;
        send(1'b1, 1'b0, 64'h99);
        check("pre_rst_rd_valid", 64'(rd_if.rd_valid), 64'd1);
        din = 64'hEE;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_wrapped", 64'(wrapped), 64'd0);
        check("mid_rst_trig_addr", 64'(trig_addr), 64'd0);
        check("mid_rst_rd_valid", 64'(rd_if.rd_valid), 64'd0);
        check("mid_rst_rd_data", 64'(rd_if.rd_data), 64'd0);
        step();
        check("in_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        quiet();
        arm_cap(1'b0, 4'd0);
        check("post_rst_arm_busy", 64'(busy), 64'd1);
        rd_check("post_rst_w0", 5'd0, 32'h55);
        rd_check("post_rst_w1", 5'd2, 32'h56);
        rd_check("post_rst_w4", 5'd8, 32'h99);
        rd_check("post_rst_w5", 5'd10, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
